// File: rtl/skid_pipeline_arbiter.sv
// Round-robin burst arbiter that shares one ready/valid stream among
// INPUT_COUNT requesters. A grant is held until the granted requester
// transfers a word flagged last, or until MAX_BURST words have transferred.
// Handshake and data of the granted requester are muxed combinationally.
// The register stages live in the downstream skid buffer pipeline.
//
// state | meaning
// IDLE  | no grant; pick the next valid requester after the previous grant
// BUSY  | requester r_grant owns the output until last or burst limit
module skid_pipeline_arbiter #(
  parameter int WORD_WIDTH   = 8,
  parameter int INPUT_COUNT  = 4,
  parameter int SOURCE_WIDTH = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic [INPUT_COUNT-1:0]            input_valid,
  output logic [INPUT_COUNT-1:0]            input_ready,
  input  logic [INPUT_COUNT*WORD_WIDTH-1:0] input_data,
  input  logic [INPUT_COUNT-1:0]            input_last,
  output logic                              output_valid,
  input  logic                              output_ready,
  output logic [WORD_WIDTH-1:0]             output_data,
  output logic                              output_last,
  output logic [SOURCE_WIDTH-1:0]           output_source
);

  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT =
    (MAX_BURST > 0) ? CNT_W'(MAX_BURST - 1) : '0;
  localparam logic [SOURCE_WIDTH-1:0] PREV_RESET = SOURCE_WIDTH'(INPUT_COUNT - 1);
  localparam logic LIMIT_ON = (MAX_BURST > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  r_state, w_state_nxt;
  logic [SOURCE_WIDTH-1:0] r_grant, w_grant_nxt;
  logic [SOURCE_WIDTH-1:0] r_prev, w_prev_nxt;
  logic [CNT_W-1:0]        r_count, w_count_nxt;
  logic [SOURCE_WIDTH-1:0] w_pick, w_idx;
  logic                    w_any;
  logic                    w_sel_valid, w_sel_last;
  logic [WORD_WIDTH-1:0]   w_sel_data;
  logic                    w_xfer, w_release;

  // Round-robin search: lowest offset after r_prev wins, so iterate downward
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int k = INPUT_COUNT; k >= 1; k--) begin
      w_idx = SOURCE_WIDTH'((int'(r_prev) + k) % INPUT_COUNT);
      if (input_valid[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  // Mux the granted requester's valid, last and data
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      if (r_grant == SOURCE_WIDTH'(i)) begin
        w_sel_valid = input_valid[i];
        w_sel_last  = input_last[i];
        w_sel_data  = input_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Transfer and release qualifiers; output_ready only gates ready and transfer
  always_comb begin
    w_xfer    = (r_state == BUSY) && w_sel_valid && output_ready && !clear;
    w_release = w_xfer && (w_sel_last || (LIMIT_ON && (r_count == LAST_BEAT)));
  end

  // Next-state and output decode; clear masks the handshake so no word is taken
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_prev_nxt    = r_prev;
    w_count_nxt   = r_count;
    input_ready   = '0;
    output_valid  = 1'b0;
    output_last   = 1'b0;
    output_data   = '0;
    output_source = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_count_nxt = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        output_valid         = w_sel_valid && !clear;
        output_last          = w_sel_last;
        output_data          = w_sel_data;
        output_source        = r_grant;
        input_ready[r_grant] = output_ready && !clear;
        if (w_xfer) begin
          w_count_nxt = r_count + 1'b1;
        end
        if (w_release) begin
          w_state_nxt = IDLE;
          w_prev_nxt  = r_grant;
          w_count_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_prev  <= PREV_RESET;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_prev  <= w_prev_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_skid_pipeline_arbiter.sv
// Directed bench for skid_pipeline_arbiter with default parameters
// (8-bit words, 4 requesters, MAX_BURST=4).
module tb_skid_pipeline_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic [3:0]  input_valid;
  logic [3:0]  input_ready;
  logic [7:0]  d [4];
  logic [31:0] input_data;
  logic [3:0]  input_last;
  logic        output_valid;
  logic        output_ready;
  logic [7:0]  output_data;
  logic        output_last;
  logic [1:0]  output_source;

  int n_checks = 0;
  int n_fail   = 0;

  assign input_data = {d[3], d[2], d[1], d[0]};

  always #5 clock = ~clock;

  skid_pipeline_arbiter #(
    .WORD_WIDTH(8), .INPUT_COUNT(4), .SOURCE_WIDTH(2), .MAX_BURST(4)
  ) dut (
    .clock(clock), .clear(clear),
    .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .input_last(input_last),
    .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data), .output_last(output_last),
    .output_source(output_source)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    clear        = 1'b1;
    input_valid  = 4'hF;
    input_last   = 4'hF;
    output_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);

    // reset held two cycles with all requesters valid
    tick();
    #1;
    chk("rst_ready1", 32'(input_ready), 32'h0);
    chk("rst_valid1", 32'(output_valid), 32'h0);
    tick();
    #1;
    chk("rst_ready2", 32'(input_ready), 32'h0);
    chk("rst_valid2", 32'(output_valid), 32'h0);
    clear = 1'b0;
    #1;
    chk("rst_idle_valid", 32'(output_valid), 32'h0);
    tick();

    // round robin, single-beat bursts
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_src", 32'(output_source), 32'(k % 4));
      chk("rr_valid", 32'(output_valid), 32'h1);
      chk("rr_data", 32'(output_data), 32'h10 + 32'(k % 4));
      chk("rr_ready", 32'(input_ready), 32'h1 << (k % 4));
      tick();
      #1;
      chk("rr_gap", 32'(output_valid), 32'h0);
      tick();
    end
    input_valid = 4'h0;
    do_clear();

    // burst limit: requester 2 streams, requester 1 waits
    input_last  = 4'h0;
    input_valid = 4'b0100;
    #1;
    chk("bl_idle", 32'(output_valid), 32'h0);
    tick();
    input_valid = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      d[2] = 8'h20 + 8'(b);
      #1;
      chk("bl_src", 32'(output_source), 32'h2);
      chk("bl_data", 32'(output_data), 32'h20 + 32'(b));
      chk("bl_ready", 32'(input_ready), 32'b0100);
      tick();
    end
    #1;
    chk("bl_release", 32'(output_valid), 32'h0);
    tick();
    d[1]       = 8'h30;
    input_last = 4'b0010;
    #1;
    chk("bl_src1", 32'(output_source), 32'h1);
    chk("bl_last1", 32'(output_last), 32'h1);
    chk("bl_data1", 32'(output_data), 32'h30);
    tick();
    #1;
    chk("bl_gap1", 32'(output_valid), 32'h0);
    tick();
    d[2] = 8'h24;
    #1;
    chk("bl_regain_src", 32'(output_source), 32'h2);
    chk("bl_regain_data", 32'(output_data), 32'h24);
    input_valid = 4'h0;
    input_last  = 4'h0;
    do_clear();

    // release on last after two beats
    input_valid = 4'b0010;
    tick();
    d[1] = 8'hA1;
    #1;
    chk("lr_src", 32'(output_source), 32'h1);
    chk("lr_d0", 32'(output_data), 32'hA1);
    chk("lr_last0", 32'(output_last), 32'h0);
    tick();
    d[1]       = 8'hA2;
    input_last = 4'b0010;
    #1;
    chk("lr_d1", 32'(output_data), 32'hA2);
    chk("lr_last1", 32'(output_last), 32'h1);
    tick();
    #1;
    chk("lr_release", 32'(output_valid), 32'h0);
    input_valid = 4'h0;
    input_last  = 4'h0;
    do_clear();

    // backpressure for three cycles mid-burst
    input_valid = 4'b0001;
    tick();
    for (int b = 0; b < 2; b++) begin
      d[0] = 8'h40 + 8'(b);
      #1;
      chk("bp_src", 32'(output_source), 32'h0);
      chk("bp_data", 32'(output_data), 32'h40 + 32'(b));
      tick();
    end
    output_ready = 1'b0;
    d[0]         = 8'h42;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("bp_stall_valid", 32'(output_valid), 32'h1);
      chk("bp_stall_data", 32'(output_data), 32'h42);
      chk("bp_stall_ready", 32'(input_ready), 32'h0);
      tick();
    end
    output_ready = 1'b1;
    for (int b = 2; b < 4; b++) begin
      d[0] = 8'h40 + 8'(b);
      #1;
      chk("bp_resume_valid", 32'(output_valid), 32'h1);
      chk("bp_resume_data", 32'(output_data), 32'h40 + 32'(b));
      chk("bp_resume_ready", 32'(input_ready), 32'h1);
      tick();
    end
    #1;
    chk("bp_done", 32'(output_valid), 32'h0);
    input_valid = 4'h0;
    do_clear();

    // clear in the middle of a burst from requester 3
    input_valid = 4'b1000;
    tick();
    for (int b = 0; b < 2; b++) begin
      d[3] = 8'h50 + 8'(b);
      #1;
      chk("mc_src3", 32'(output_source), 32'h3);
      tick();
    end
    input_valid = 4'b1001;
    d[3]        = 8'h52;
    clear       = 1'b1;
    #1;
    chk("mc_clr_valid", 32'(output_valid), 32'h0);
    chk("mc_clr_ready", 32'(input_ready), 32'h0);
    tick();
    clear = 1'b0;
    #1;
    chk("mc_idle", 32'(output_valid), 32'h0);
    tick();
    #1;
    chk("mc_src0", 32'(output_source), 32'h0);
    chk("mc_valid0", 32'(output_valid), 32'h1);

    input_valid = 4'b1100;
    do_clear();
    #1;
    chk("mc2_idle", 32'(output_valid), 32'h0);
    tick();
    #1;
    chk("mc2_src", 32'(output_source), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skid_pipeline_arbiter.md
Name: skid_pipeline_arbiter

Overview:
Round-robin arbiter that shares one ready/valid pipeline among INPUT_COUNT requesters. A grant lasts for a whole burst: until the granted requester transfers a word flagged last, or until MAX_BURST words have transferred. The selected requester's handshake and data are muxed combinationally onto a single output. The output feeds a downstream skid buffer pipeline of any depth, which supplies the register stages.

Parameters:
WORD_WIDTH, 8, data width per requester.
INPUT_COUNT, 4, number of requesters; must be >= 2.
SOURCE_WIDTH, 2, width of the source index; must equal ceil(log2(INPUT_COUNT)).
MAX_BURST, 4, maximum words per grant; 0 = unlimited, so release happens only on last.

Ports:
clock  input  1  single clock; all state updates on rising edge.
clear  input  1  synchronous, active-high reset.
input_valid  input  INPUT_COUNT  per-requester valid.
input_ready  output  INPUT_COUNT  per-requester ready.
input_data  input  INPUT_COUNT*WORD_WIDTH  packed data; requester i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
input_last  input  INPUT_COUNT  per-requester end-of-burst flag.
output_valid  output  1  valid toward the pipeline.
output_ready  input  1  ready from the pipeline.
output_data  output  WORD_WIDTH  muxed data.
output_last  output  1  muxed last flag.
output_source  output  SOURCE_WIDTH  index of the granted requester.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on clear.
- Reset state: clear forces state IDLE, grant index 0, previous-grant pointer INPUT_COUNT-1 (so requester 0 has top priority first), beat counter 0. clear overrides all other events in the same cycle.
- State IDLE:
  - input_ready all 0; output_valid, output_last, output_data and output_source all 0.
  - If any input_valid is 1, pick the first valid requester searching from (previous pointer + 1) mod INPUT_COUNT upward with wrap.
  - Register that index as the grant; next state BUSY, counter 0.
  - Arbitration therefore costs exactly one idle cycle; no word transfers in IDLE.
- State BUSY, granted index g:
  - output_valid = input_valid[g]; output_data = data[g]; output_last = input_last[g]; output_source = g.
  - input_ready[g] = output_ready; every other input_ready is 0.
  - All of these are combinational: zero latency through the block.
- Transfer definition: a word transfers when output_valid and output_ready are both 1 in BUSY. Each transfer increments the counter.
- Release: on a transfer where input_last[g]=1, or where counter == MAX_BURST-1 (MAX_BURST>0).
  - Next state IDLE; previous pointer <- g; counter <- 0.
  - The cycle after a release always has output_valid=0.
- Requester deasserts valid mid-burst: grant is held and the counter is unchanged. No timeout.
- Non-granted requesters: may hold valid indefinitely and see input_ready=0. The round-robin order guarantees service within INPUT_COUNT-1 intervening bursts.
- output_ready low: no transfer and no counter change, so the burst stalls cleanly.
- Counter width: ceil(log2(MAX_BURST+1)). With MAX_BURST=0 the counter still counts but is ignored for release.
- clear mid-burst: the word presented in that cycle is not counted. The next cycle is IDLE with requester 0 at top priority.
- No combinational path from output_ready to output_valid, so the block is safe against a skid buffer input.

Test Plan:
- Reset: hold clear 2 cycles with all valids=1 -> input_ready=0000 and output_valid=0 during clear. First grant (output_source) is 0 one cycle after clear falls.
- Round-robin: all 4 valid, each sends last on its 1st beat, output_ready=1 -> output_source sequence 0,1,2,3,0 with an idle cycle (output_valid=0) between grants.
- Burst limit: MAX_BURST=4, requester 2 streams 10 words with last=0 and requester 1 also valid -> words 0-3 from source 2, then source 3 if valid else 0 else 1 per rotation. Requester 2 regains the grant only after the others are served.
- Last release: requester 1 sends 0xA1, 0xA2 (last=1) -> grant released after 2 beats even though MAX_BURST=4.
- Backpressure: output_ready low for 3 cycles mid-burst -> output_data stable, input_ready[g]=0, counter unchanged. The burst resumes and completes with exactly MAX_BURST transfers.
- Mid-burst clear: requester 3 granted after 2 beats, clear pulses -> next cycle IDLE. Requester 0 wins if valid, else the next valid index upward from 0.
